// File: rtl/tile_fetch_pkg.sv
// rtl/tile_fetch_pkg.sv - shared constants and FSM state type for the tile fetch unit
package tile_fetch_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_TILE_ELEMS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/tile_serializer.sv
// rtl/tile_serializer.sv - holds one fetched tile and presents its elements in order
module tile_serializer
  import tile_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TILE_ELEMS = DEF_TILE_ELEMS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load,
  input  logic signed [DATA_WIDTH-1:0] tile_in [TILE_ELEMS],
  input  logic                         advance,
  output logic signed [DATA_WIDTH-1:0] elem,
  output logic                         tile_end
);

  localparam int IDX_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

  logic signed [DATA_WIDTH-1:0] tile_q [TILE_ELEMS];
  logic [IDX_W-1:0]             idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TILE_ELEMS; i++) tile_q[i] <= '0;
      idx <= '0;
    end else if (load) begin
      tile_q <= tile_in;
      idx    <= '0;
    end else if (advance) begin
      idx <= idx + 1'b1;
    end
  end

  assign elem     = tile_q[idx];
  assign tile_end = (idx == IDX_W'(TILE_ELEMS - 1));

endmodule

// File: rtl/tile_fetch_unit.sv
// rtl/tile_fetch_unit.sv - fetches tiles from a vector buffer and streams a command's elements
module tile_fetch_unit
  import tile_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TILE_ELEMS = DEF_TILE_ELEMS,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [4:0]                   cmd_buffer_id,
  input  logic [LEN_WIDTH-1:0]         cmd_length,
  output logic                         rd_enable,
  output logic [4:0]                   rd_buffer_id,
  input  logic signed [DATA_WIDTH-1:0] rd_tile [TILE_ELEMS],
  input  logic                         rd_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  fetch_state_t                 state;
  logic [LEN_WIDTH-1:0]         remaining;
  logic [WAIT_W-1:0]            wait_cnt;
  logic                         timed_out;
  logic                         load;
  logic                         xfer;
  logic                         tile_end;
  logic signed [DATA_WIDTH-1:0] elem;

  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = !cmd_ready;
  assign rd_enable   = (state == ST_REQ);
  assign out_valid   = (state == ST_DRAIN);
  assign xfer        = out_valid && out_ready;
  assign out_last    = out_valid && (remaining == LEN_WIDTH'(1));
  assign out_data    = out_valid ? elem : '0;
  assign done        = (state == ST_DONE);
  assign timeout_err = done && timed_out;
  // rd_valid is only meaningful while a request is outstanding
  assign load        = (state == ST_WAIT) && rd_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      wait_cnt     <= '0;
      timed_out    <= 1'b0;
      rd_buffer_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rd_buffer_id <= cmd_buffer_id;
            remaining    <= cmd_length;
            timed_out    <= 1'b0;
            if (cmd_length == '0) state <= ST_DONE;
            else                  state <= ST_REQ;
          end
        end
        ST_REQ: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rd_valid) begin
            state <= ST_DRAIN;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            timed_out <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (remaining != '0) remaining <= remaining - 1'b1;
            if (remaining <= LEN_WIDTH'(1)) state <= ST_DONE;
            else if (tile_end)              state <= ST_REQ;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  tile_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .TILE_ELEMS(TILE_ELEMS)
  ) u_serializer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .tile_in (rd_tile),
    .advance (xfer),
    .elem    (elem),
    .tile_end(tile_end)
  );

endmodule
